// File: rtl/fibo_arbiter.sv
// fibo_arbiter: round-robin sequencer sharing one Fibonacci unit among N_REQ requesters.
// One job in flight at a time; a watchdog aborts jobs the unit never completes.
module fibo_arbiter #(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned IDX_W   = 5,
  localparam int unsigned F_W     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [IDX_W*N_REQ-1:0] idx,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [F_W-1:0]         resp_f,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   fibo_start,
  output logic [IDX_W-1:0]       fibo_i,
  input  logic                   fibo_ready,
  input  logic                   fibo_done_tick,
  input  logic [F_W-1:0]         fibo_f
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [F_W-1:0]    res_q, res_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [F_W-1:0]    resp_f_q, resp_f_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic              fibo_start_q, fibo_start_d;
  logic [IDX_W-1:0]  fibo_i_q, fibo_i_d;

  logic [IDX_W-1:0]  idx_a [N_REQ];
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  int unsigned       cand;

  for (genvar k = 0; k < N_REQ; k++) begin : g_idx
    assign idx_a[k] = idx[k*IDX_W +: IDX_W];
  end

  // Round-robin search starting at ptr_q, wrapping modulo N_REQ
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = 0;
    for (int unsigned o = 0; o < N_REQ; o++) begin
      cand = 32'(ptr_q) + o;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_vld && req[ID_W'(cand)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(cand);
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    res_d   = res_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (win_vld && fibo_ready) begin
          id_d    = win_id;
          idx_d   = idx_a[win_id];
          ptr_d   = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
          state_d = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // done_tick takes precedence over a coincident timeout
        if (fibo_done_tick) begin
          res_d   = fibo_f;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gnt_d        = '0;
    resp_valid_d = '0;
    resp_f_d     = '0;
    resp_err_d   = 1'b0;
    fibo_start_d = 1'b0;
    fibo_i_d     = '0;
    busy_d       = (state_d != IDLE);
    if (state_d == START) begin
      gnt_d[id_d]  = 1'b1;
      fibo_start_d = 1'b1;
      fibo_i_d     = idx_d;
    end
    if (state_d == RESP) begin
      resp_valid_d[id_d] = 1'b1;
      resp_f_d           = res_d;
      resp_err_d         = err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      idx_q        <= '0;
      wd_q         <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_f_q     <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      fibo_start_q <= 1'b0;
      fibo_i_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      res_q        <= res_d;
      err_q        <= err_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_f_q     <= resp_f_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      fibo_start_q <= fibo_start_d;
      fibo_i_q     <= fibo_i_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_f     = resp_f_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign fibo_start = fibo_start_q;
  assign fibo_i     = fibo_i_q;

endmodule

// File: tb/tb_fibo_arbiter.sv
// tb_fibo_arbiter: vector table, hand-written corner sequences and a randomized run
// against a round-robin reference model, with a behavioural Fibonacci unit stub.
module tb_fibo_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [5*N-1:0] idx;
  logic [N-1:0]  gnt, resp_valid;
  logic [19:0]   resp_f;
  logic          resp_err, busy, fibo_start;
  logic [4:0]    fibo_i;
  logic          fibo_ready, fibo_done_tick;
  logic [19:0]   fibo_f;

  int n_tests = 0;
  int n_fail  = 0;

  fibo_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .idx(idx),
    .gnt(gnt), .resp_valid(resp_valid), .resp_f(resp_f), .resp_err(resp_err),
    .busy(busy), .fibo_start(fibo_start), .fibo_i(fibo_i),
    .fibo_ready(fibo_ready), .fibo_done_tick(fibo_done_tick), .fibo_f(fibo_f)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] fib(input int n);
    logic [19:0] a, b, t;
    a = 20'd0;
    b = 20'd1;
    for (int j = 0; j < n; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Shared-unit stub: max(i,1) op cycles; in hang mode it silently never pulses done
  logic       hang;
  logic       u_busy, u_done;
  int         u_cnt;
  logic [4:0] u_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      u_busy <= 1'b0;
      u_done <= 1'b0;
      u_cnt  <= 0;
      u_i    <= 5'd0;
    end else begin
      u_done <= 1'b0;
      if (fibo_start && !u_busy) begin
        u_busy <= 1'b1;
        u_cnt  <= (fibo_i == 5'd0) ? 1 : int'(fibo_i);
        u_i    <= fibo_i;
      end else if (u_busy) begin
        if (u_cnt == 1) begin
          u_busy <= 1'b0;
          u_done <= !hang;
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end
    end
  end
  assign fibo_ready     = !u_busy;
  assign fibo_done_tick = u_done;
  assign fibo_f         = u_done ? fib(int'(u_i)) : 20'hABCDE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'(|{gnt, resp_valid, resp_f, resp_err, busy, fibo_start, fibo_i});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Single request raised at cycle 0; checks grant/response timing and payload
  task automatic run_single(input int id, input logic [4:0] i, input logic [19:0] ef,
                            input int ecyc, input logic eerr);
    int gcyc, rcyc;
    logic [N-1:0] gv, rv;
    logic [4:0] fi;
    logic [19:0] rf;
    logic re, gs;
    gcyc = -1; rcyc = -1; gv = '0; rv = '0; fi = '0; rf = '0; re = 1'b0; gs = 1'b0;
    idx[id*5 +: 5] = i;
    req[id] = 1'b1;
    for (int t = 1; t <= 150; t++) begin
      @(negedge clk);
      if (gnt != '0 && gcyc < 0) begin
        gcyc = t; gv = gnt; fi = fibo_i; gs = fibo_start & busy;
        req[id] = 1'b0;
      end
      if (resp_valid != '0) begin
        rcyc = t; rv = resp_valid; rf = resp_f; re = resp_err;
        break;
      end
    end
    req[id] = 1'b0;
    chk("single_gnt_cycle", 32'(gcyc), 32'd1);
    chk("single_gnt_vec", 32'(gv), 32'(1 << id));
    chk("single_start_busy", 32'(gs), 32'd1);
    chk("single_fibo_i", 32'(fi), 32'(i));
    chk("single_resp_cycle", 32'(rcyc), 32'(ecyc));
    chk("single_resp_vec", 32'(rv), 32'(1 << id));
    chk("single_resp_f", 32'(rf), 32'(ef));
    chk("single_resp_err", 32'(re), 32'(eerr));
    @(negedge clk);
    @(negedge clk);
  endtask

  // Several simultaneous requests; expected grant order given as packed 2-bit ids
  task automatic run_group(input logic [N-1:0] mask, input logic [5*N-1:0] iv,
                           input logic [7:0] ord, input int n);
    int ng, nr, ovl, e;
    ng = 0; nr = 0; ovl = 0;
    idx = iv;
    req = mask;
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk);
      if ((gnt & resp_valid) != '0) ovl++;
      if (gnt != '0) begin
        e = (ng < n) ? int'(ord[ng*2 +: 2]) : 0;
        chk("group_gnt_order", 32'(gnt), 32'(1 << e));
        chk("group_fibo_i", 32'(fibo_i), 32'(iv[e*5 +: 5]));
        req = req & ~gnt;
        ng++;
      end
      if (resp_valid != '0) begin
        e = (nr < n) ? int'(ord[nr*2 +: 2]) : 0;
        chk("group_resp_vec", 32'(resp_valid), 32'(1 << e));
        chk("group_resp_f", 32'(resp_f), 32'(fib(int'(iv[e*5 +: 5]))));
        nr++;
        if (nr == n) break;
      end
    end
    req = '0;
    chk("group_resp_count", 32'(nr), 32'(n));
    chk("group_overlap", 32'(ovl), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int         id;
    logic [4:0] i;
    logic [19:0] f;
    int         cyc;
    logic       err;
    logic       hang;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int ptr_m, out_id, ew, aid, issued, served, ovl;
    bit out_m;
    logic [4:0] out_idx;
    logic [N-1:0] ev;

    vecs[0] = '{2, 5'd10, 20'd55,     13,     1'b0, 1'b0};
    vecs[1] = '{0, 5'd0,  20'd0,      4,      1'b0, 1'b0};
    vecs[2] = '{1, 5'd1,  20'd1,      4,      1'b0, 1'b0};
    vecs[3] = '{3, 5'd2,  20'd1,      5,      1'b0, 1'b0};
    vecs[4] = '{0, 5'd30, 20'd832040, 33,     1'b0, 1'b0};
    vecs[5] = '{1, 5'd31, 20'd297693, 34,     1'b0, 1'b0};
    vecs[6] = '{3, 5'd5,  20'd0,      TO + 2, 1'b1, 1'b1};
    vecs[7] = '{0, 5'd6,  20'd8,      9,      1'b0, 1'b0};

    rst = 1'b1; req = '0; idx = '0; hang = 1'b0;
    do_reset();

    for (int v = 0; v < 8; v++) begin
      hang = vecs[v].hang;
      run_single(vecs[v].id, vecs[v].i, vecs[v].f, vecs[v].cyc, vecs[v].err);
    end
    hang = 1'b0;

    // All four at once from a fresh pointer: 0,1,2,3
    do_reset();
    run_group(4'b1111, {5'd9, 5'd7, 5'd5, 5'd3}, {2'd3, 2'd2, 2'd1, 2'd0}, 4);

    // Rotation: after serving 1, requesters 0 and 2 together -> 2 then 0
    run_single(1, 5'd4, 20'd3, 7, 1'b0);
    run_group(4'b0101, {5'd0, 5'd8, 5'd0, 5'd12}, {4'd0, 2'd0, 2'd2}, 2);

    // Reset in the middle of WAIT discards the job and clears the pointer
    idx[1*5 +: 5] = 5'd20;
    req[1] = 1'b1;
    @(negedge clk);
    chk("midwait_gnt", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    for (int t = 0; t < 6; t++) @(negedge clk);
    chk("midwait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_rst_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    ovl = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (resp_valid != '0 || busy) ovl++;
    end
    chk("midwait_no_resp", 32'(ovl), 32'd0);
    run_group(4'b1001, {5'd4, 5'd0, 5'd0, 5'd20}, {4'd0, 2'd3, 2'd0}, 2);

    // Randomized traffic against a round-robin reference model
    do_reset();
    ptr_m = 0; out_m = 1'b0; out_id = 0; out_idx = '0;
    issued = 0; served = 0; ovl = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ((gnt & resp_valid) != '0) ovl++;
      if (gnt != '0) begin
        ew = -1;
        for (int o = 0; o < N; o++) begin
          if (ew < 0 && req[(ptr_m + o) % N]) ew = (ptr_m + o) % N;
        end
        ev = (ew < 0) ? '0 : N'(1 << ew);
        aid = 0;
        for (int k = N - 1; k >= 0; k--) if (gnt[k]) aid = k;
        chk("rnd_gnt_while_busy", 32'(out_m), 32'd0);
        chk("rnd_winner", 32'(gnt), 32'(ev));
        chk("rnd_fibo_i", 32'(fibo_i), 32'(idx[aid*5 +: 5]));
        out_m = 1'b1; out_id = aid; out_idx = idx[aid*5 +: 5];
        ptr_m = (aid + 1) % N;
        req[aid] = 1'b0;
      end
      if (resp_valid != '0) begin
        chk("rnd_resp_expected", 32'(out_m), 32'd1);
        chk("rnd_resp_vec", 32'(resp_valid), 32'(1 << out_id));
        chk("rnd_resp_f", 32'(resp_f), 32'(fib(int'(out_idx))));
        chk("rnd_resp_err", 32'(resp_err), 32'd0);
        out_m = 1'b0;
        served++;
      end
      if (c < 2600) begin
        for (int k = 0; k < N; k++) begin
          if (!req[k] && !(out_m && out_id == k) && $urandom_range(3) == 0) begin
            idx[k*5 +: 5] = 5'($urandom_range(31));
            req[k] = 1'b1;
            issued++;
          end
        end
      end
    end
    chk("rnd_all_served", 32'(served), 32'(issued));
    chk("rnd_overlap", 32'(ovl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fibo_arbiter.md
# fibo_arbiter

Round-robin arbiter and sequencer that shares one Fibonacci unit (`fibo`) between N_REQ requesters. It accepts index requests, launches the shared unit with the winner's index, and waits for `done_tick`. It then returns the 20-bit result to that requester with a one-cycle response pulse. A watchdog terminates any job the unit fails to complete.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 64, maximum cycles in WAIT before the job is aborted (must be > 32)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  request level per requester
- idx  in  5*N_REQ  index per requester, idx[k*5 +: 5], stable while req[k] high
- gnt  out  N_REQ  one-hot, one-cycle pulse: request k accepted
- resp_valid  out  N_REQ  one-hot, one-cycle pulse: result for requester k
- resp_f  out  20  result, valid only while resp_valid != 0
- resp_err  out  1  timeout flag, valid only while resp_valid != 0
- busy  out  1  high in every state except IDLE
- fibo_start  out  1  start pulse to shared unit
- fibo_i  out  5  index to shared unit
- fibo_ready  in  1  unit idle
- fibo_done_tick  in  1  unit finished, one-cycle pulse
- fibo_f  in  20  unit result, valid during fibo_done_tick

## Operation
- Reset values: gnt=0, resp_valid=0, resp_f=0, resp_err=0, busy=0, fibo_start=0, fibo_i=0; state=IDLE; rr pointer=0; watchdog=0.
- The FSM is Moore with four states: IDLE, START, WAIT, RESP.
- IDLE: when any req is high and fibo_ready=1, select the winner by round-robin. Register its id and idx[id]. Go to START. Otherwise stay.
- Round-robin search order: ptr, ptr+1, …, wrapping modulo N_REQ. After a grant, ptr = id+1 (mod N_REQ). After reset, requester 0 has highest priority.
- START: gnt[id]=1, fibo_start=1, fibo_i=captured idx, all for exactly one cycle. Clear the watchdog. Go to WAIT.
- WAIT: increment the watchdog each cycle.
  - On fibo_done_tick: register fibo_f and set err=0. Go to RESP.
  - Else, when watchdog == TIMEOUT-1: set result=0 and err=1. Go to RESP.
  - If done_tick arrives in the same cycle as the timeout condition, done_tick wins (err=0).
- RESP: resp_valid[id]=1, resp_f=result, resp_err=err for one cycle. Go to IDLE.
- Requester rule: drop req[k] no later than the cycle after gnt[k]. If req[k] is still high in IDLE after RESP, it is treated as a new request.
- Requests that are not granted stay pending. The arbiter never drops or reorders them beyond the round-robin rule.
- Result width is 20 bits. Values wrap modulo 2^20: F(30)=832040 is exact; F(31) returns 297693.
- The fibo convention is F(0)=0, F(1)=1, F(2)=1.
- A reset in any state returns the block to IDLE next cycle with all outputs at reset values. An in-flight job is discarded with no resp_valid. The shared unit is reset by the same rst.

## Timing
- Request at cycle 0, in IDLE, with fibo_ready=1:
  - gnt and fibo_start at cycle 1.
  - With the unit taking L=max(i,1) op cycles, fibo_done_tick arrives at cycle 2+L.
  - resp_valid at cycle 3+L.
- Back-to-back: the next grant comes no earlier than 2 cycles after resp_valid.
- At most one job is outstanding. gnt and resp_valid are never high in the same cycle.
- If fibo_ready=0, IDLE waits with no grant.

## Test plan
- Single request, req[2] with idx=10 at cycle 0 → gnt[2] at cycle 1, fibo_i=10, resp_valid[2] at cycle 13, resp_f=55, resp_err=0.
- Boundary indices i=0, 1, 2, 30, 31 → resp_f = 0, 1, 1, 832040, 297693, each at cycle 4, 4, 5, 33, 34 respectively.
- All four req high at the same time, each with a distinct idx → grants in order 0, 1, 2, 3. Each resp_f matches its own idx. No pulse overlaps.
- Rotation: after serving requester 1, raise req[0] and req[2] together → requester 2 is granted first, then requester 0.
- Timeout: use a stub unit that never pulses done_tick → resp_valid for the granted id TIMEOUT+1 cycles after gnt, with resp_err=1 and resp_f=0. The next request is then served normally.
- Reset mid-WAIT with i=20, then release reset → no resp_valid, all outputs 0, ptr=0. A new request idx=20 returns 6765.
